inst_fetch_unit: RTL

- Fetch stage of the RISC-V core. Owns the PC and issues word reads to instruction memory over a valid/ready request channel; responses return in order.
- Fetched instructions are buffered in a small FIFO and presented to decode, which slices inst[31:7] for the immediate generator.
- Accepts a redirect (branch/jump target, computed from the immediate) that flushes everything in flight.

---
 rtl/core_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/inst_fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared fetch-stage types: data width, reset vector, FSM states and the FIFO entry.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fall-through FIFO of fetched {inst, pc} entries with synchronous flush.
// Latency: a push becomes visible at head the cycle after; head is read with zero latency.
// Backpressure: push while full is accepted only together with a pop.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to imem and buffers responses for decode.
// Latency: response cycle writes the FIFO, if_valid rises the next cycle.
// Backpressure: requests stop once outstanding + buffered reaches DEPTH; redirect flushes all.
module inst_fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   stale, stale_d;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            fifo_full, fifo_empty;
    logic            req_fire, rsp_in_flight, rsp_live, push, pop;
    fetch_entry_t    head;

    assign target_pc      = {redirect_pc[XLEN-1:2], 2'b00};
    assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = (state == S_RUN) && (credit_used < (CW + 1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing in flight (e.g. memory not reset with us) are ignored.
    assign rsp_in_flight = imem_rsp_valid && (stale != '0 || outstanding != '0);
    assign rsp_live      = imem_rsp_valid && (stale == '0) && (outstanding != '0);
    assign push          = rsp_live && !redirect_valid;

    assign if_valid = !fifo_empty && !redirect_valid;
    assign pop      = if_valid && if_ready;
    assign if_inst  = fifo_empty ? '0 : head.inst;
    assign if_pc    = fifo_empty ? '0 : head.pc;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry ('{inst: imem_rsp_data, pc: rsp_pc}),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        stale_d = stale;
        if (redirect_valid)
            stale_d = stale + outstanding + CW'(req_fire) - CW'(rsp_in_flight);
        else if (imem_rsp_valid && stale != '0)
            stale_d = stale - 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_BOOT:  state_next = S_RUN;
            S_RUN,
            S_FLUSH: state_next = (stale_d != '0) ? S_FLUSH : S_RUN;
            default: state_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
        end else begin
            state <= state_next;
            stale <= stale_d;
            if (redirect_valid) begin
                pc          <= target_pc;
                rsp_pc      <= target_pc;
                outstanding <= '0;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                if (push)     rsp_pc <= rsp_pc + 32'd4;
                outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);
            end
        end
    end

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        (imem_rsp_valid && stale == '0) |-> (outstanding != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (!fifo_full || pop));

endmodule
